// File: rtl/sinfonia_pkg.sv
// Shared types and helpers for the Sinfonia do Espectro melody sequencer.
package sinfonia_pkg;

  // Playback controller states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_PLAY  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } estado_t;

  // Buzzer code meaning "no sound".
  localparam logic [2:0] NOTA_SILENCIO = 3'd0;

  // Converts a one-hot button pattern into {valid, buzzer code}.
  // Bit i alone gives code i+1; zero or multi-hot patterns are invalid.
  function automatic logic [3:0] onehot_para_nota(input logic [6:0] padrao);
    logic [3:0] res;
    case (padrao)
      7'b0000001: res = {1'b1, 3'd1};
      7'b0000010: res = {1'b1, 3'd2};
      7'b0000100: res = {1'b1, 3'd3};
      7'b0001000: res = {1'b1, 3'd4};
      7'b0010000: res = {1'b1, 3'd5};
      7'b0100000: res = {1'b1, 3'd6};
      7'b1000000: res = {1'b1, 3'd7};
      default:    res = {1'b0, NOTA_SILENCIO};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/temporizador_nota.sv
// Loadable down-counter shared by the note and gap phases.
// Loading `valor` makes `fim` rise after exactly `valor` cycles of counting.
module temporizador_nota #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carrega,
  input  logic [W-1:0] valor,
  input  logic         conta,
  output logic         fim
);

  logic [W-1:0] cnt;

  // Load has priority over counting; the counter parks at zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (carrega) begin
      cnt <= valor - W'(1);
    end else if (conta && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign fim = (cnt == '0);

endmodule

// File: rtl/sequenciador_notas.sv
// Melody playback controller: walks the note memory from address 0 to the
// latched limit, sounding each note for N cycles followed by a G-cycle gap.
// Optional feature macro: SEQ_NIVEL_RAPIDO_EN (latched nivel=1 halves N and G).
//
// Handshake: `start` is a one-cycle request honoured only in IDLE; `stop`
// aborts from any state and wins over `start`; `done` pulses one cycle on
// normal completion; `busy` covers FETCH, PLAY and GAP.
module sequenciador_notas
  import sinfonia_pkg::*;
#(
  parameter int NOTE_TICKS = 50_000_000,
  parameter int GAP_TICKS  = 12_500_000,
  parameter int ADDR_W     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] limite,
  input  logic              nivel,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [6:0]        mem_data,
  output logic [2:0]        arduino_out,
  output logic [6:0]        leds,
  output logic              busy,
  output logic              done,
  output logic              erro_nota,
  output estado_t           estado
);

  localparam int TW          = $clog2(NOTE_TICKS + 1);
  localparam int NOTE_RAPIDO = NOTE_TICKS >> 1;
  localparam int GAP_RAPIDO  = ((GAP_TICKS >> 1) < 1) ? 1 : (GAP_TICKS >> 1);

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] limite_q;
  logic              erro_q;
  logic              aceita;
  logic              carrega, conta, fim;
  logic [TW-1:0]     valor, ticks_nota, ticks_gap;
  logic [3:0]        nota_dec;

  assign aceita   = (estado_q == ST_IDLE) && start && !stop;
  assign nota_dec = onehot_para_nota(mem_data);

`ifdef SEQ_NIVEL_RAPIDO_EN
  logic nivel_q;

  // Difficulty level is captured with the request and held for the whole melody.
  always_ff @(posedge clock) begin
    if (!reset) begin
      nivel_q <= 1'b0;
    end else if (aceita) begin
      nivel_q <= nivel;
    end
  end

  assign ticks_nota = nivel_q ? TW'(NOTE_RAPIDO) : TW'(NOTE_TICKS);
  assign ticks_gap  = nivel_q ? TW'(GAP_RAPIDO)  : TW'(GAP_TICKS);
`else
  logic unused_nivel;
  assign unused_nivel = nivel ^ (NOTE_RAPIDO != GAP_RAPIDO);
  assign ticks_nota   = TW'(NOTE_TICKS);
  assign ticks_gap    = TW'(GAP_TICKS);
`endif

  temporizador_nota #(.W(TW)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .carrega (carrega),
    .valor   (valor),
    .conta   (conta),
    .fim     (fim)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= ST_IDLE;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic and timer control; the timer is loaded on the edge
  // that enters PLAY or GAP so it expires after exactly N or G cycles there.
  always_comb begin
    estado_d = estado_q;
    carrega  = 1'b0;
    conta    = 1'b0;
    valor    = ticks_nota;
    case (estado_q)
      ST_IDLE: begin
        if (start) estado_d = ST_FETCH;
      end
      ST_FETCH: begin
        estado_d = ST_PLAY;
        carrega  = 1'b1;
        valor    = ticks_nota;
      end
      ST_PLAY: begin
        conta = 1'b1;
        if (fim) begin
          estado_d = ST_GAP;
          carrega  = 1'b1;
          valor    = ticks_gap;
        end
      end
      ST_GAP: begin
        conta = 1'b1;
        if (fim) estado_d = (addr_q == limite_q) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        estado_d = ST_IDLE;
      end
      default: begin
        estado_d = ST_IDLE;
      end
    endcase
    if (stop) estado_d = ST_IDLE;
  end

  // Address walk, latched limit and sticky bad-pattern flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      addr_q   <= '0;
      limite_q <= '0;
      erro_q   <= 1'b0;
    end else if (aceita) begin
      addr_q   <= '0;
      limite_q <= limite;
      erro_q   <= 1'b0;
    end else begin
      if ((estado_q == ST_GAP) && fim && (addr_q != limite_q) && !stop) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      if ((estado_q == ST_PLAY) && !nota_dec[3]) begin
        erro_q <= 1'b1;
      end
    end
  end

  // Outputs derive only from the state register and the memory's output
  // register, so the first note appears the cycle after FETCH.
  assign arduino_out = ((estado_q == ST_PLAY) && nota_dec[3]) ? nota_dec[2:0] : NOTA_SILENCIO;
  assign leds        = ((estado_q == ST_PLAY) && nota_dec[3]) ? mem_data : 7'd0;
  assign busy        = (estado_q == ST_FETCH) || (estado_q == ST_PLAY) || (estado_q == ST_GAP);
  assign done        = (estado_q == ST_DONE);
  assign mem_addr    = addr_q;
  assign erro_nota   = erro_q;
  assign estado      = estado_q;

endmodule

// File: tb/tb_sequenciador_notas.sv
// Self-checking bench for sequenciador_notas with NOTE_TICKS=4, GAP_TICKS=2.
// Table-driven playback runs plus hand-written error/abort/reset sequences.
module tb_sequenciador_notas;
  import sinfonia_pkg::*;

  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset, start, stop, nivel;
  logic [AW-1:0] limite;
  logic [AW-1:0] mem_addr;
  logic [6:0]    mem_data;
  logic [2:0]    arduino_out;
  logic [6:0]    leds;
  logic          busy, done, erro_nota;
  estado_t       estado;

  logic [6:0] mem [16];

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic       start;
    logic       stop;
    logic [3:0] lim;
    logic [2:0] exp_ard;
    logic [6:0] exp_leds;
    logic       exp_busy;
    logic       exp_done;
    logic [3:0] exp_addr;
  } vec_t;

  vec_t tab [32];
  int   ntab;

  logic [2:0] code_tab [3];
  logic [6:0] leds_tab [3];

  sequenciador_notas #(
    .NOTE_TICKS (4),
    .GAP_TICKS  (2),
    .ADDR_W     (AW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .limite      (limite),
    .nivel       (nivel),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .arduino_out (arduino_out),
    .leds        (leds),
    .busy        (busy),
    .done        (done),
    .erro_nota   (erro_nota),
    .estado      (estado)
  );

  // Clock.
  always #5 clock = ~clock;

  // Synchronous note memory, one-cycle read latency.
  always @(posedge clock) mem_data <= mem[mem_addr];

  // Watchdog.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected per-cycle outputs for a start at cycle 0 with the given limit.
  // Slot s: FETCH at 1+7s, PLAY 2+7s..5+7s, GAP 6+7s..7+7s; done at 1+7(lim+1).
  task automatic build_play(input int lim, input int ncyc, input logic [3:0] prev_addr,
                            input int ign_start);
    int done_c;
    done_c = 1 + 7 * (lim + 1);
    for (int c = 0; c < ncyc; c++) begin
      tab[c].start    = (c == 0) || (c == ign_start);
      tab[c].stop     = 1'b0;
      tab[c].lim      = (c == 0) ? 4'(lim) : 4'd9;
      tab[c].exp_ard  = 3'd0;
      tab[c].exp_leds = 7'd0;
      tab[c].exp_busy = 1'b0;
      tab[c].exp_done = 1'b0;
      tab[c].exp_addr = prev_addr;
      if (c >= 1 && c < done_c) begin
        int s, off;
        s   = (c - 1) / 7;
        off = (c - 1) % 7;
        tab[c].exp_busy = 1'b1;
        tab[c].exp_addr = 4'(s);
        if (off >= 1 && off <= 4) begin
          tab[c].exp_ard  = code_tab[s];
          tab[c].exp_leds = leds_tab[s];
        end
      end else if (c >= done_c) begin
        tab[c].exp_addr = 4'(lim);
        tab[c].exp_done = (c == done_c);
      end
    end
    ntab = ncyc;
  endtask

  task automatic apply_tab(input string tag);
    for (int i = 0; i < ntab; i++) begin
      start  = tab[i].start;
      stop   = tab[i].stop;
      limite = tab[i].lim;
      check($sformatf("%s c%0d out", tag, i), {20'd0, arduino_out, leds, busy, done},
            {20'd0, tab[i].exp_ard, tab[i].exp_leds, tab[i].exp_busy, tab[i].exp_done});
      check($sformatf("%s c%0d addr", tag, i), 32'(mem_addr), 32'(tab[i].exp_addr));
      tick();
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    int done_cnt, busy_cnt;
    int ard_lo, ard_hi, busy_hi, done_c;

    code_tab = '{3'd1, 3'd3, 3'd7};
    leds_tab = '{7'b0000001, 7'b0000100, 7'b1000000};
    for (int i = 0; i < 16; i++) mem[i] = 7'd0;
    mem[0] = 7'b0000001;
    mem[1] = 7'b0000100;
    mem[2] = 7'b1000000;

    reset = 1'b0; start = 1'b0; stop = 1'b0; nivel = 1'b0; limite = '0;

    // Reset held for three cycles.
    repeat (3) tick();
    check("rst outs", {25'd0, arduino_out, leds, busy, done, erro_nota},
          {25'd0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0});
    check("rst addr", 32'(mem_addr), 32'd0);
    check("rst state", 32'(estado), 32'(ST_IDLE));
    reset = 1'b1;
    tick();

    // Three-note melody, limit changes and a second start mid-run are ignored.
    build_play(2, 24, 4'd0, 10);
    apply_tab("play3");

    // Single note.
    build_play(0, 10, 4'd2, -1);
    apply_tab("play1");

    // Multi-hot pattern: silent note and sticky error.
    mem[0] = 7'b0000011;
    limite = 4'd0; start = 1'b1;
    tick(); start = 1'b0;                       // cycle 1
    tick();                                      // cycle 2
    check("bad play out", {21'd0, arduino_out, leds, busy}, {21'd0, 3'd0, 7'd0, 1'b1});
    tick();                                      // cycle 3
    check("bad erro set", 32'(erro_nota), 32'd1);
    repeat (5) tick();                           // cycle 8
    check("bad done", 32'(done), 32'd1);
    repeat (2) tick();                           // cycle 10
    check("bad erro sticky", {30'd0, erro_nota, busy}, {30'd0, 1'b1, 1'b0});
    mem[0] = 7'b0010000;
    start = 1'b1;
    tick(); start = 1'b0;                        // cycle 1
    check("erro cleared", 32'(erro_nota), 32'd0);
    tick();                                      // cycle 2
    check("note5 out", {22'd0, arduino_out, leds}, {22'd0, 3'd5, 7'b0010000});
    repeat (8) tick();
    mem[0] = 7'b0000001;

    // Stop during playback.
    limite = 4'd2; start = 1'b1;
    tick(); start = 1'b0;                        // cycle 1
    repeat (2) tick();                           // cycle 3
    check("pre stop busy", 32'(busy), 32'd1);
    stop = 1'b1;
    tick(); stop = 1'b0;                         // cycle 4
    check("stop outs", {21'd0, arduino_out, leds, busy, done},
          {21'd0, 3'd0, 7'd0, 1'b0, 1'b0});
    check("stop state", 32'(estado), 32'(ST_IDLE));
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check("stop no done", 32'(done_cnt), 32'd0);

    // Stop wins over start.
    start = 1'b1; stop = 1'b1;
    tick(); start = 1'b0; stop = 1'b0;
    check("stop over start", {31'd0, busy}, 32'd0);
    check("stop over start st", 32'(estado), 32'(ST_IDLE));

    // Reset in the second gap.
    limite = 4'd2; start = 1'b1;
    tick(); start = 1'b0;                        // cycle 1
    repeat (12) tick();                          // cycle 13
    check("mid gap state", 32'(estado), 32'(ST_GAP));
    check("mid gap addr", 32'(mem_addr), 32'd1);
    reset = 1'b0;
    tick(); reset = 1'b1;                        // cycle 14
    check("rst gap outs", {25'd0, arduino_out, leds, busy, done, erro_nota},
          {25'd0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0});
    check("rst gap addr", 32'(mem_addr), 32'd0);
    done_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      tick();
    end
    check("rst gap no done", 32'(done_cnt), 32'd0);
    check("rst gap no busy", 32'(busy_cnt), 32'd0);

    // Fast level: halved times when the feature is built in, ignored otherwise.
`ifdef SEQ_NIVEL_RAPIDO_EN
    ard_lo = 2; ard_hi = 3; busy_hi = 4; done_c = 5;
`else
    ard_lo = 2; ard_hi = 5; busy_hi = 7; done_c = 8;
`endif
    nivel = 1'b1; limite = 4'd0; start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      logic [2:0] ea;
      logic       eb, ed;
      ea = (c >= ard_lo && c <= ard_hi) ? 3'd1 : 3'd0;
      eb = (c >= 1 && c <= busy_hi);
      ed = (c == done_c);
      check($sformatf("nivel c%0d", c), {27'd0, arduino_out, busy, done}, {27'd0, ea, eb, ed});
      tick();
      start = 1'b0;
    end
    nivel = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
